max7219_chain_monitor: RTL and testbench

Parametrised bus-level monitor and emulator for a daisy chain of G_NB_MATRIX MAX7219 8x8 LED drivers, instantiated in testbenches beside the DUT's MAX7219 serial interface. It oversamples the serial clock, data and load lines on the bench clock and strictly checks frame length. On each valid load it commits one 16-bit word per device into a per-device register file. Benches read the rendered matrix rows through a request/valid port.

---
 rtl/max7219_chain_monitor.sv | 173 +++++++++++++++++
 tb/tb_max7219_chain_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_chain_monitor.sv
// max7219_chain_monitor: oversampling bus monitor and emulator for a chain of
// MAX7219 LED drivers. It shifts the serial stream, commits one word per
// device on a correctly sized load, and serves rendered matrix rows on request.
module max7219_chain_monitor #(
    parameter int G_NB_MATRIX   = 8,
    parameter int G_SYNC_STAGES = 2
) (
    input  logic                                                     clk,
    input  logic                                                     rst_n,
    input  logic                                                     i_max7219_clk,
    input  logic                                                     i_max7219_din,
    input  logic                                                     i_max7219_load,
    output logic                                                     o_max7219_dout,
    input  logic                                                     i_rd_req,
    input  logic [((G_NB_MATRIX > 1) ? $clog2(G_NB_MATRIX) : 1)-1:0] i_rd_matrix,
    input  logic [2:0]                                               i_rd_row,
    output logic                                                     o_rd_valid,
    output logic [7:0]                                               o_rd_data,
    output logic [15:0]                                              o_frame_cnt,
    output logic                                                     o_err_len,
    input  logic                                                     i_err_clr,
    output logic [G_NB_MATRIX-1:0]                                   o_shutdown,
    output logic [G_NB_MATRIX-1:0]                                   o_display_test
);

    localparam int MW  = (G_NB_MATRIX > 1) ? $clog2(G_NB_MATRIX) : 1;
    localparam int SW  = $clog2(G_SYNC_STAGES);
    localparam int SRW = 16 * G_NB_MATRIX;
    localparam int CW  = $clog2(SRW + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(SRW);
    localparam logic [CW-1:0] CNT_SAT  = CW'(SRW + 1);

    // Synchroniser chains, bit order {load, din, sclk}
    logic [2:0]     r_sync [G_SYNC_STAGES];
    logic           r_hist_clk;
    logic           r_hist_load;
    logic [2:0]     w_sync;
    logic           w_sclk_rise;
    logic           w_load_rise;
    logic           w_din;

    logic [SRW-1:0] r_sr;
    logic [CW-1:0]  r_cnt;
    logic [SRW-1:0] w_sr_nx;
    logic [CW-1:0]  w_cnt_nx;
    logic           w_commit;
    logic           w_len_err;
    logic [11:0]    w_word [G_NB_MATRIX];

    logic [7:0]     r_digit [G_NB_MATRIX][8];
    logic [2:0]     r_scanlimit [G_NB_MATRIX];
    logic [7:0]     w_rd_pix;

    // Synchronise the three serial pins and keep one history flop for edges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < G_SYNC_STAGES; i++) begin
                r_sync[SW'(i)] <= '0;
            end
            r_hist_clk  <= 1'b0;
            r_hist_load <= 1'b0;
        end else begin
            r_sync[0] <= {i_max7219_load, i_max7219_din, i_max7219_clk};
            for (int unsigned i = 1; i < G_SYNC_STAGES; i++) begin
                r_sync[SW'(i)] <= r_sync[SW'(i - 1)];
            end
            r_hist_clk  <= w_sync[0];
            r_hist_load <= w_sync[2];
        end
    end

    assign w_sync      = r_sync[G_SYNC_STAGES-1];
    assign w_sclk_rise = w_sync[0] & ~r_hist_clk;
    assign w_load_rise = w_sync[2] & ~r_hist_load;
    assign w_din       = w_sync[1];

    // Next shift/count state; a load in the same cycle sees the post-shift values
    always_comb begin
        w_sr_nx  = r_sr;
        w_cnt_nx = r_cnt;
        if (w_sclk_rise) begin
            w_sr_nx = {r_sr[SRW-2:0], w_din};
            if (r_cnt != CNT_SAT) begin
                w_cnt_nx = r_cnt + CW'(1);
            end
        end
        w_commit  = w_load_rise && (w_cnt_nx == CNT_FULL);
        w_len_err = w_load_rise && (w_cnt_nx != CNT_FULL) && (w_cnt_nx != '0);
        for (int unsigned d = 0; d < G_NB_MATRIX; d++) begin
            w_word[MW'(d)] = w_sr_nx[16*d +: 12];
        end
    end

    // Shift register, bit counter, frame counter and sticky length error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            o_frame_cnt <= '0;
            o_err_len   <= 1'b0;
        end else begin
            r_sr  <= w_sr_nx;
            r_cnt <= w_load_rise ? '0 : w_cnt_nx;
            if (w_commit) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
            if (w_len_err) begin
                o_err_len <= 1'b1;
            end else if (i_err_clr) begin
                o_err_len <= 1'b0;
            end
        end
    end

    assign o_max7219_dout = r_sr[SRW-1];

    // Per-device register file written on commit. DECODE and INTENSITY writes
    // are accepted but influence no output, so they are not kept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned d = 0; d < G_NB_MATRIX; d++) begin
                for (int unsigned c = 0; c < 8; c++) begin
                    r_digit[MW'(d)][3'(c)] <= '0;
                end
                r_scanlimit[MW'(d)] <= '0;
            end
            o_shutdown     <= '1;
            o_display_test <= '0;
        end else if (w_commit) begin
            for (int unsigned d = 0; d < G_NB_MATRIX; d++) begin
                case (w_word[MW'(d)][11:8])
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8:
                        r_digit[MW'(d)][3'(w_word[MW'(d)][11:8] - 4'd1)] <= w_word[MW'(d)][7:0];
                    4'hB: r_scanlimit[MW'(d)] <= w_word[MW'(d)][2:0];
                    4'hC: o_shutdown[d]       <= ~w_word[MW'(d)][0];
                    4'hF: o_display_test[d]   <= w_word[MW'(d)][0];
                    default: ;
                endcase
            end
        end
    end

    // Render the requested row: out-of-range, display test, shutdown, then pixels
    always_comb begin
        w_rd_pix = '0;
        if (int'(i_rd_matrix) < G_NB_MATRIX) begin
            if (o_display_test[i_rd_matrix]) begin
                w_rd_pix = 8'hFF;
            end else if (!o_shutdown[i_rd_matrix]) begin
                for (int unsigned c = 0; c < 8; c++) begin
                    // ~row == 7 - row for a 3-bit index: row 0 is digit bit 7
                    if (c <= 32'(r_scanlimit[i_rd_matrix])) begin
                        w_rd_pix[3'(c)] = r_digit[i_rd_matrix][3'(c)][~i_rd_row];
                    end
                end
            end
        end
    end

    // Registered read port: one valid pulse per request, data held between pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= i_rd_req;
            if (i_rd_req) begin
                o_rd_data <= w_rd_pix;
            end
        end
    end

endmodule

// File: tb/tb_max7219_chain_monitor.sv
// tb_max7219_chain_monitor: drives directed and random serial frames into the
// chain monitor and compares every observable against a frame-level model.
module tb_max7219_chain_monitor;

    localparam int LP_N   = 5;
    localparam int LP_SRW = 16 * LP_N;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sclk = 1'b0;
    logic            din = 1'b0;
    logic            load = 1'b0;
    logic            dout;
    logic            rd_req = 1'b0;
    logic [2:0]      rd_matrix = '0;
    logic [2:0]      rd_row = '0;
    logic            rd_valid;
    logic [7:0]      rd_data;
    logic [15:0]     frame_cnt;
    logic            err_len;
    logic            err_clr = 1'b0;
    logic [LP_N-1:0] shutdown;
    logic [LP_N-1:0] disp_test;

    max7219_chain_monitor #(
        .G_NB_MATRIX  (LP_N),
        .G_SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_max7219_clk (sclk),
        .i_max7219_din (din),
        .i_max7219_load(load),
        .o_max7219_dout(dout),
        .i_rd_req      (rd_req),
        .i_rd_matrix   (rd_matrix),
        .i_rd_row      (rd_row),
        .o_rd_valid    (rd_valid),
        .o_rd_data     (rd_data),
        .o_frame_cnt   (frame_cnt),
        .o_err_len     (err_len),
        .i_err_clr     (err_clr),
        .o_shutdown    (shutdown),
        .o_display_test(disp_test)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]      m_digit [LP_N][8];
    logic [2:0]      m_scan [LP_N];
    logic [LP_N-1:0] m_shut;
    logic [LP_N-1:0] m_test;
    logic [15:0]     m_frames;
    logic            m_err;
    int              m_bits;
    bit              m_q[$];
    logic [15:0]     f_words [LP_N];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_row(input int m, input int row);
        logic [7:0] r;
        r = '0;
        if (m >= LP_N) return 8'h00;
        if (m_test[m]) return 8'hFF;
        if (m_shut[m]) return 8'h00;
        for (int c = 0; c < 8; c++) begin
            if (c <= int'(m_scan[m])) r[c] = m_digit[m][c][7 - row];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < LP_N; d++) begin
            for (int c = 0; c < 8; c++) m_digit[d][c] = '0;
            m_scan[d] = '0;
        end
        m_shut   = '1;
        m_test   = '0;
        m_frames = '0;
        m_err    = 1'b0;
        m_bits   = 0;
        m_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; sclk = 1'b0; din = 1'b0; load = 1'b0;
        rd_req = 1'b0; err_clr = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    // One serial bit with comfortable high/low phases, then check DOUT
    task automatic sbit(input bit b);
        int sz;
        @(negedge clk);
        din = b;
        @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        m_q.push_back(b);
        if (m_bits < LP_SRW + 1) m_bits++;
        sz = m_q.size();
        check_val("dout", 32'(dout), (sz >= LP_SRW) ? 32'(m_q[sz - LP_SRW]) : 32'd0);
    endtask

    task automatic send_frame();
        for (int d = LP_N - 1; d >= 0; d--) begin
            for (int b = 15; b >= 0; b--) sbit(f_words[d][b]);
        end
    endtask

    task automatic send_random_bits(input int n);
        for (int i = 0; i < n; i++) sbit(1'($urandom));
    endtask

    // Load pulse; the model decodes the last frame straight from the bit history
    task automatic do_load();
        int sz;
        logic [15:0] w;
        @(negedge clk);
        load = 1'b1;
        repeat (4) @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        sz = m_q.size();
        if (m_bits == LP_SRW) begin
            for (int d = 0; d < LP_N; d++) begin
                for (int j = 0; j < 16; j++) w[j] = m_q[sz - 1 - (16 * d + j)];
                if (w[11:8] >= 4'h1 && w[11:8] <= 4'h8) m_digit[d][int'(w[11:8]) - 1] = w[7:0];
                else if (w[11:8] == 4'hB) m_scan[d] = w[2:0];
                else if (w[11:8] == 4'hC) m_shut[d] = ~w[0];
                else if (w[11:8] == 4'hF) m_test[d] = w[0];
            end
            m_frames = m_frames + 16'd1;
        end else if (m_bits != 0) begin
            m_err = 1'b1;
        end
        m_bits = 0;
    endtask

    task automatic do_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_read(input int m, input int row);
        logic [7:0] e;
        @(negedge clk);
        rd_req    = 1'b1;
        rd_matrix = 3'(m);
        rd_row    = 3'(row);
        e = exp_row(m, row);
        @(negedge clk);
        rd_req = 1'b0;
        check_val($sformatf("rd_valid m%0d r%0d", m, row), 32'(rd_valid), 32'd1);
        check_val($sformatf("rd_data m%0d r%0d", m, row), 32'(rd_data), 32'(e));
        @(negedge clk);
        check_val("rd_valid_drop", 32'(rd_valid), 32'd0);
        check_val("rd_data_hold", 32'(rd_data), 32'(e));
    endtask

    task automatic check_status(input string tag);
        check_val({tag, " frame_cnt"}, 32'(frame_cnt), 32'(m_frames));
        check_val({tag, " err_len"}, 32'(err_len), 32'(m_err));
        check_val({tag, " shutdown"}, 32'(shutdown), 32'(m_shut));
        check_val({tag, " display_test"}, 32'(disp_test), 32'(m_test));
    endtask

    task automatic set_all(input logic [15:0] w);
        for (int d = 0; d < LP_N; d++) f_words[d] = w;
    endtask

    task automatic set_one(input int m, input logic [15:0] w);
        set_all(16'h0000);
        f_words[m] = w;
    endtask

    initial begin
        do_reset();
        check_status("reset");
        check_val("reset shutdown ones", 32'(shutdown), 32'h1F);
        do_read(0, 0);

        set_all(16'h0C01); send_frame(); do_load();
        check_val("wake shutdown", 32'(shutdown), 32'h00);
        set_all(16'h0B07); send_frame(); do_load();
        check_val("frame_cnt two", 32'(frame_cnt), 32'd2);
        check_status("setup");

        set_one(0, 16'h0181); send_frame(); do_load();
        do_read(0, 0); do_read(0, 7); do_read(1, 0);
        check_val("m0 row0 literal", 32'(exp_row(0, 0)), 32'h01);

        set_one(0, 16'h0180); send_frame(); do_load();
        set_one(0, 16'h0280); send_frame(); do_load();
        do_read(0, 0);
        set_one(0, 16'h0B00); send_frame(); do_load();
        do_read(0, 0);
        check_status("scanlimit");

        send_random_bits(40); do_load();
        check_status("short frame");
        do_read(0, 0);
        do_err_clr();
        check_status("err clear");

        set_one(2, 16'h0F01); send_frame(); do_load();
        do_read(2, 3); do_read(2, 0);
        for (int m = LP_N; m < 8; m++) do_read(m, 0);
        check_status("disptest");

        // Mid-frame reset, then a load with nothing shifted is not an error
        send_random_bits(20);
        do_reset();
        do_load();
        check_status("post reset load");
        set_all(16'h0C01); send_frame(); do_load(); do_load();
        check_status("double load");

        // Idle clocking pushes the last frame out through DOUT; the load then overflows
        send_random_bits(LP_SRW + 3);
        do_load();
        check_status("overflow");
        do_err_clr();

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                int n;
                n = $urandom_range(1, LP_SRW + 10);
                if (n == LP_SRW) n = LP_SRW - 1;
                send_random_bits(n);
            end else begin
                for (int d = 0; d < LP_N; d++) f_words[d] = 16'($urandom);
                send_frame();
            end
            do_load();
            check_status("random");
            for (int k = 0; k < 3; k++) do_read($urandom_range(0, 7), $urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) do_err_clr();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
